alu_hold_stage: RTL

- Datapath ALU stage of the 6502 core, directly downstream of the A-input register (AI) and B-input register (BI).
- Consumes the AI and BI operands and performs one of five ALU operations under a START strobe.
- Latches the result into the ADD hold register together with the carry, overflow and half-carry flags.
- For decimal-mode addition, applies a BCD adjust in a second cycle. ADD is then driven onto the SB/ADL buses by downstream logic.

---
 rtl/alu_hold_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_hold_stage.sv
// rtl/alu_hold_stage.sv - 6502 ALU stage with ADD hold register and two-cycle BCD adjust
module alu_hold_stage #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             OP_SUMS,
  input  logic             OP_ANDS,
  input  logic             OP_EORS,
  input  logic             OP_ORS,
  input  logic             OP_SRS,
  input  logic             CARRY_IN,
  input  logic             DECIMAL_EN,
  input  logic             START,
  output logic [WIDTH-1:0] ADD,
  output logic             ACR,
  output logic             AVR,
  output logic             HC,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {IDLE, ADJ} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] add_nxt;
  logic             acr_nxt, avr_nxt, hc_nxt, done_nxt;

  logic [WIDTH:0]   sum_full;
  logic [4:0]       sum_low;
  logic [WIDTH:0]   adj_lo, adj_hi;

  assign sum_full = {1'b0, AI} + {1'b0, BI} + {{WIDTH{1'b0}}, CARRY_IN};
  assign sum_low  = {1'b0, AI[3:0]} + {1'b0, BI[3:0]} + {4'b0000, CARRY_IN};

  // Decimal adjust works on the registered binary sum, never on live inputs.
  assign adj_lo = {1'b0, ADD} +
                  ((HC || (ADD[3:0] > 4'd9)) ? (WIDTH+1)'(6) : (WIDTH+1)'(0));
  assign adj_hi = adj_lo +
                  ((ACR || (adj_lo[WIDTH:4] > (WIDTH-3)'(9))) ? (WIDTH+1)'(96) : (WIDTH+1)'(0));

  always_comb begin
    state_nxt = state;
    add_nxt   = ADD;
    acr_nxt   = ACR;
    avr_nxt   = AVR;
    hc_nxt    = HC;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          add_nxt  = '0;
          acr_nxt  = 1'b0;
          avr_nxt  = 1'b0;
          hc_nxt   = 1'b0;
          done_nxt = 1'b1;
          if (OP_SUMS) begin
            add_nxt = sum_full[WIDTH-1:0];
            acr_nxt = sum_full[WIDTH];
            hc_nxt  = sum_low[4];
            avr_nxt = (AI[WIDTH-1] == BI[WIDTH-1]) &&
                      (sum_full[WIDTH-1] != AI[WIDTH-1]);
            if (DECIMAL_EN) begin
              state_nxt = ADJ;
              done_nxt  = 1'b0;
            end
          end else if (OP_ANDS) begin
            add_nxt = AI & BI;
          end else if (OP_EORS) begin
            add_nxt = AI ^ BI;
          end else if (OP_ORS) begin
            add_nxt = AI | BI;
          end else if (OP_SRS) begin
            add_nxt = {CARRY_IN, AI[WIDTH-1:1]};
            acr_nxt = AI[0];
          end
        end
      end
      ADJ: begin
        add_nxt   = adj_hi[WIDTH-1:0];
        acr_nxt   = ACR | adj_hi[WIDTH];
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ADD   <= '0;
      ACR   <= 1'b0;
      AVR   <= 1'b0;
      HC    <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      ADD   <= add_nxt;
      ACR   <= acr_nxt;
      AVR   <= avr_nxt;
      HC    <= hc_nxt;
      DONE  <= done_nxt;
    end
  end

  assign BUSY = (state == ADJ);

endmodule
